counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Controller that owns and sequences a WIDTH-bit up-counter for timer and event-pacing use.
- Accepts start/stop/hold commands and latches a period and prescale at start.
- Runs in one-shot or auto-reload mode.
- Emits single-cycle tick (terminal count) and done (one-shot completion) pulses for downstream logic.

Parameters:
WIDTH, 8, counter/period width in bits
PRESC_WIDTH, 4, prescaler width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset=0 asserts)
start  input  1  begin a run; sampled each clk
stop  input  1  abort a run; highest command priority
hold  input  1  pause counting while high
mode  input  1  0 = one-shot, 1 = auto-reload; latched at start
period  input  WIDTH  terminal count value; latched at start
prescale  input  PRESC_WIDTH  step every prescale+1 clocks; latched at start
value  output  WIDTH  current count, registered
busy  output  1  high in RUN or HOLD
tick  output  1  one-cycle pulse on terminal-count wrap
done  output  1  one-cycle pulse when a one-shot run completes
overrun  output  1  one-cycle pulse when start is seen while busy

Behaviour:
- Reset: asynchronous on reset=0.
  - State goes to IDLE.
  - value, busy, tick, done and overrun go to 0.
  - Prescale counter and latched period/prescale/mode go to 0.
  - Outputs stay in this state while reset=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RUN, HOLD.
- Command priority in a cycle: stop > start > hold.
- IDLE:
  - start=1 and stop=0: latch period, prescale and mode; clear value and prescale counter to 0; go to RUN. busy=1 from the next cycle.
  - start=1 and stop=1 together: stay in IDLE, no latch.
- RUN:
  - The prescale counter increments every clk.
  - When the prescale counter equals the latched prescale, it clears to 0 and a step occurs.
  - On a step with value < latched period: value increments by 1.
  - On a step with value == latched period: value goes to 0 and tick=1 for one cycle.
  - One-shot mode: the same edge also sets done=1 for one cycle, moves to IDLE and clears busy.
- Interval: tick interval is (period+1)*(prescale+1) clocks. The first tick comes that many clocks after the start edge.
- Arithmetic: unsigned. value never exceeds the latched period, so period = 2^WIDTH-1 wraps cleanly with no overflow.
- period=0: every step produces a tick.
- HOLD:
  - Entered from RUN when hold=1 (and no stop).
  - value and the prescale counter freeze; no tick or done.
  - hold=0 returns to RUN and resumes from the frozen prescale count.
- stop in RUN or HOLD: go to IDLE next edge; value goes to 0; busy goes to 0; no tick or done pulse.
- stop in IDLE: no effect.
- start while state != IDLE (including the one-shot completion cycle): ignored; overrun=1 for one cycle; the run is unaffected.
- Changes to period, prescale or mode inputs while busy are ignored until the next accepted start.
- Reset asserted mid-run: immediate return to the reset state; any pending tick or done is discarded.

Test Plan:
1. Reset: run auto-reload with period=5, then drive reset=0 asynchronously mid-cycle -> value, busy, tick, done and overrun are all 0 before the next clk edge; after release, outputs stay idle until start.
2. One-shot, period=3, prescale=0, start at edge 0 -> value 0,1,2,3,0 on edges 0..4; tick and done both high exactly one cycle after edge 4; busy high after edges 0..3 and low after edge 4; no further ticks.
3. Auto-reload, period=2, prescale=1 -> tick every 6 clocks; exactly 3 ticks in 18 clocks after start; busy stays high; done never asserts.
4. Auto-reload, period=4, prescale=0; hold=1 for 5 cycles while value=2 -> value holds at 2 for those cycles; first tick is delayed by exactly 5 clocks versus the no-hold run.
5. Run busy with period=10, assert start for 1 cycle at value=3 -> overrun pulses once and value continues 4,5,...; then stop=1 together with hold=1 -> next cycle is IDLE with value=0, busy=0 and no tick.
6. Boundaries:
   - period=0, prescale=0, auto-reload -> tick every clock with value constantly 0.
   - period=255, prescale=0 -> value reaches 255, then wraps to 0 with tick, and never reads 256 or an X value.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences a WIDTH-bit up-counter for timer / event pacing.
// Start latches period, prescale and mode; the counter steps every prescale+1
// clocks and wraps at the latched period with a tick pulse. One-shot runs end
// with a done pulse; auto-reload runs continue until stop.
module counter_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   hold,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       period,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]       value,
    output logic                   busy,
    output logic                   tick,
    output logic                   done,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state;
    logic [PRESC_WIDTH-1:0] psc_cnt;
    logic [WIDTH-1:0]       period_q;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic                   mode_q;

    // Command decode, prescaler, counter and pulse outputs in one registered FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            psc_cnt  <= '0;
            period_q <= '0;
            presc_q  <= '0;
            mode_q   <= 1'b0;
            value    <= '0;
            busy     <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tick    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        period_q <= period;
                        presc_q  <= prescale;
                        mode_q   <= mode;
                        value    <= '0;
                        psc_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (stop) begin
                        value   <= '0;
                        psc_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        if (start) begin
                            overrun <= 1'b1;
                        end
                        if (hold) begin
                            state <= HOLD;
                        end else begin
                            // Leaving HOLD counts on the same edge, so a hold of
                            // N cycles delays the run by exactly N clocks.
                            state <= RUN;
                            if (psc_cnt == presc_q) begin
                                psc_cnt <= '0;
                                if (value == period_q) begin
                                    value <= '0;
                                    tick  <= 1'b1;
                                    if (!mode_q) begin
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                        state <= IDLE;
                                    end
                                end else begin
                                    value <= value + WIDTH'(1);
                                end
                            end else begin
                                psc_cnt <= psc_cnt + PRESC_WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    value <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: directed scenarios followed by random
// command traffic, all compared against an elapsed-clock reference model.
module tb_counter_sequencer;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned PRESC_WIDTH = 4;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic                   stop;
    logic                   hold;
    logic                   mode;
    logic [WIDTH-1:0]       period;
    logic [PRESC_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]       value;
    logic                   busy;
    logic                   tick;
    logic                   done;
    logic                   overrun;

    counter_sequencer #(
        .WIDTH       (WIDTH),
        .PRESC_WIDTH (PRESC_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .value    (value),
        .busy     (busy),
        .tick     (tick),
        .done     (done),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is described by the number of counting clocks
    // since start; value and tick follow from plain division.
    bit          m_active;
    int unsigned m_cnt;
    int unsigned m_p;
    int unsigned m_s;
    bit          m_m;
    int unsigned e_value;
    bit          e_tick;
    bit          e_done;
    bit          e_ovr;

    task automatic model_reset();
        m_active = 0; m_cnt = 0; m_p = 0; m_s = 0; m_m = 0;
        e_value = 0; e_tick = 0; e_done = 0; e_ovr = 0;
    endtask

    task automatic model_edge();
        int unsigned len;
        e_tick = 0; e_done = 0; e_ovr = 0;
        if (!reset) begin
            model_reset();
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1; m_cnt = 0;
                m_p = period; m_s = prescale; m_m = mode;
                e_value = 0;
            end
        end else if (stop) begin
            m_active = 0; e_value = 0;
        end else begin
            if (start) e_ovr = 1;
            if (!hold) begin
                len = (m_p + 1) * (m_s + 1);
                m_cnt++;
                e_value = (m_cnt / (m_s + 1)) % (m_p + 1);
                if (m_cnt % len == 0) begin
                    e_tick = 1;
                    if (!m_m) begin
                        e_done = 1; m_active = 0; e_value = 0;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("value",   32'(value),   32'(e_value));
        check("busy",    32'(busy),    32'(m_active));
        check("tick",    32'(tick),    32'(e_tick));
        check("done",    32'(done),    32'(e_done));
        check("overrun", 32'(overrun), 32'(e_ovr));
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic clear_cmds();
        start = 0; stop = 0; hold = 0;
    endtask

    task automatic do_start(input bit m, input int unsigned p, input int unsigned s);
        start = 1; mode = m; period = WIDTH'(p); prescale = PRESC_WIDTH'(s);
        step();
        clear_cmds();
        // scrambled config inputs must not disturb the latched run
        period = WIDTH'($urandom); prescale = PRESC_WIDTH'($urandom); mode = 1'($urandom);
    endtask

    initial begin
        int n_tick;
        int n_done;
        int first;
        int max_v;
        bit saw_x;

        reset = 0; start = 0; stop = 0; hold = 0; mode = 0; period = '0; prescale = '0;
        model_reset();
        #12;
        check_outputs();
        #3 reset = 1;
        step();

        // 1. async reset mid-run
        do_start(1, 5, 0);
        repeat (3) step();
        #2 reset = 0;
        #1;
        model_reset();
        check_outputs();
        step();
        #3 reset = 1;
        repeat (3) step();

        // 2. one-shot, period 3, prescale 0
        do_start(0, 3, 0);
        n_tick = 0; n_done = 0; first = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (tick) n_tick++;
            if (done) n_done++;
            if (done && first == 0) first = i;
        end
        check("oneshot_ticks", 32'(n_tick), 32'd1);
        check("oneshot_done_edge", 32'(first), 32'd4);

        // 3. auto-reload, period 2, prescale 1: 3 ticks in 18 clocks
        do_start(1, 2, 1);
        n_tick = 0; n_done = 0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (tick) n_tick++;
            if (done) n_done++;
        end
        check("auto_ticks", 32'(n_tick), 32'd3);
        check("auto_done", 32'(n_done), 32'd0);
        stop = 1; step(); clear_cmds();

        // 4. hold for 5 cycles at value 2 delays first tick by 5
        do_start(1, 4, 0);
        repeat (2) step();
        check("hold_entry_value", 32'(value), 32'd2);
        hold = 1;
        first = 0;
        for (int i = 3; i <= 7; i++) begin
            step();
            check("hold_frozen", 32'(value), 32'd2);
        end
        hold = 0;
        for (int i = 8; i <= 14; i++) begin
            step();
            if (tick && first == 0) first = i;
        end
        check("hold_first_tick", 32'(first), 32'd10);
        stop = 1; step(); clear_cmds();

        // 5. overrun at value 3, then stop together with hold
        do_start(1, 10, 0);
        repeat (3) step();
        start = 1; step(); clear_cmds();
        check("overrun_value", 32'(value), 32'd4);
        step();
        check("continue_value", 32'(value), 32'd5);
        stop = 1; hold = 1; step(); clear_cmds();
        check("stop_value", 32'(value), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        step();

        // 6a. period 0: tick every clock
        do_start(1, 0, 0);
        n_tick = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick) n_tick++;
        end
        check("p0_ticks", 32'(n_tick), 32'd8);
        stop = 1; step(); clear_cmds();

        // 6b. period 255 one-shot: clean wrap
        do_start(0, 255, 0);
        max_v = 0; saw_x = 0; first = 0;
        for (int i = 1; i <= 260; i++) begin
            step();
            if ($isunknown(value)) saw_x = 1;
            if (int'(value) > max_v) max_v = int'(value);
            if (tick && first == 0) first = i;
        end
        check("p255_max", 32'(max_v), 32'd255);
        check("p255_wrap_edge", 32'(first), 32'd256);
        check("p255_no_x", 32'(saw_x), 32'd0);

        // random command traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 63) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            mode  = 1'($urandom);
            period = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
            prescale = PRESC_WIDTH'($urandom_range(0, 3));
            step();
        end
        clear_cmds();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
